// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package counter_pkg;

    typedef enum logic {DIR_DOWN, DIR_UP} dir_e;

    typedef enum logic {MODE_WRAP, MODE_SATURATE} mode_e;

    // Register width needed to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: produces one tick every PRESCALE enabled cycles.
// Latency: tick is combinational from the internal count and en.
// Backpressure: none; the count only advances while en is high and holds otherwise.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // With PRESCALE = 1 the count never leaves 0, so tick simply follows en.
    assign tick = en && (cnt == LAST);

    // Count enabled cycles, restarting on tick, clear or reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable modulo up/down counter with wrap/saturate mode, prescaled enable and terminal-count pulse.
// Latency: 1 cycle from a qualifying edge to count/tc; zero is combinational from count.
// Backpressure: none; steps are taken only on prescaler ticks, otherwise the count holds.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 5,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int          PRESCALE  = 1,
    parameter mode_e       MODE      = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  dir_e             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    // Reject parameter combinations the counter cannot represent.
    if (WIDTH < 1 || PRESCALE < 1 || MAX_COUNT < 1 ||
        64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH/MAX_COUNT/PRESCALE combination");
    end

    localparam logic [WIDTH-1:0] MAXV     = MAX_COUNT[WIDTH-1:0];
    localparam bit               SATURATE = (MODE == MODE_SATURATE);

    logic step;

    // Prescaler restarts whenever the count is cleared or reloaded.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear || load),
        .en   (enable),
        .tick (step)
    );

    assign zero = (count == '0);

    // Count and terminal-count register: rst > clear > load > step.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            // Out-of-range loads clamp so count never exceeds the terminal value.
            count <= (data > MAXV) ? MAXV : data;
            tc    <= 1'b0;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (count >= MAXV) begin
                    count <= SATURATE ? MAXV : '0;
                    tc    <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                    tc    <= 1'b0;
                end
            end else begin
                if (count == '0) begin
                    count <= SATURATE ? '0 : MAXV;
                    tc    <= 1'b1;
                end else begin
                    count <= count - WIDTH'(1);
                    tc    <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule
